// File: rtl/lsu_byte_master.sv
// rtl/lsu_byte_master.sv - byte-serial load/store master splitting CPU accesses into single-byte memory beats
module lsu_byte_master #(
    parameter int unsigned ADDR_LIMIT = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_func3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [31:0] mem_addr,
    output logic [2:0]  mem_func3,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

    state_t      state_q;
    logic        we_q;
    logic [2:0]  func3_q;
    logic [31:0] base_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic [1:0]  cnt_q;
    logic [1:0]  last_q;
    logic        mem_read_q;
    logic        mem_write_q;
    logic [31:0] mem_addr_q;
    logic [2:0]  mem_func3_q;
    logic [31:0] mem_wdata_q;
    logic        resp_valid_q;
    logic        resp_err_q;
    logic [31:0] resp_rdata_q;

    logic [1:0]  req_last;
    logic        req_legal;
    logic [32:0] req_end;
    logic        req_ok;
    logic [1:0]  cnt_inc;
    logic [7:0]  next_byte;
    logic [31:0] rdata_d;
    logic [31:0] resp_rdata_d;
    logic        unused_rdata;

    // Only the low byte of each memory read carries data: every beat is an LBU.
    assign unused_rdata = ^mem_rdata[31:8];

    always_comb begin
        req_last  = 2'd0;
        req_legal = 1'b0;
        case (req_func3)
            3'b000: begin req_last = 2'd0; req_legal = 1'b1; end
            3'b001: begin req_last = 2'd1; req_legal = 1'b1; end
            3'b010: begin req_last = 2'd3; req_legal = 1'b1; end
            3'b100, 3'b101: begin
                req_last  = {1'b0, req_func3[0]};
                req_legal = !req_we;
            end
            default: ;
        endcase
        // 33-bit sum so addresses near 2^32 cannot wrap into the legal range.
        req_end = {1'b0, req_addr} + {31'b0, req_last} + 33'd1;
        req_ok  = req_legal && (req_end <= 33'(ADDR_LIMIT));
    end

    always_comb begin
        cnt_inc   = cnt_q + 2'd1;
        next_byte = wdata_q[{cnt_inc, 3'b000} +: 8];
        rdata_d   = rdata_q;
        rdata_d[{cnt_q, 3'b000} +: 8] = mem_rdata[7:0];
        case (func3_q)
            3'b000:  resp_rdata_d = {{24{rdata_d[7]}}, rdata_d[7:0]};
            3'b001:  resp_rdata_d = {{16{rdata_d[15]}}, rdata_d[15:0]};
            3'b100:  resp_rdata_d = {24'b0, rdata_d[7:0]};
            3'b101:  resp_rdata_d = {16'b0, rdata_d[15:0]};
            default: resp_rdata_d = rdata_d;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            we_q         <= 1'b0;
            func3_q      <= 3'b0;
            base_q       <= 32'b0;
            wdata_q      <= 32'b0;
            rdata_q      <= 32'b0;
            cnt_q        <= 2'd0;
            last_q       <= 2'd0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= 32'b0;
            mem_func3_q  <= 3'b0;
            mem_wdata_q  <= 32'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        func3_q <= req_func3;
                        base_q  <= req_addr;
                        wdata_q <= req_wdata;
                        rdata_q <= 32'b0;
                        cnt_q   <= 2'd0;
                        last_q  <= req_last;
                        if (!req_ok) begin
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                        end else begin
                            // Beat 0 is presented in the cycle right after acceptance.
                            state_q     <= ACCESS;
                            mem_read_q  <= !req_we;
                            mem_write_q <= req_we;
                            mem_addr_q  <= req_addr;
                            mem_func3_q <= req_we ? 3'b000 : 3'b100;
                            mem_wdata_q <= req_we ? {24'b0, req_wdata[7:0]} : 32'b0;
                        end
                    end
                end
                ACCESS: begin
                    if (!we_q) begin
                        rdata_q <= rdata_d;
                    end
                    if (cnt_q == last_q) begin
                        state_q      <= RESP;
                        mem_read_q   <= 1'b0;
                        mem_write_q  <= 1'b0;
                        mem_addr_q   <= 32'b0;
                        mem_func3_q  <= 3'b0;
                        mem_wdata_q  <= 32'b0;
                        resp_valid_q <= 1'b1;
                        resp_rdata_q <= we_q ? 32'b0 : resp_rdata_d;
                    end else begin
                        cnt_q       <= cnt_inc;
                        mem_addr_q  <= base_q + {30'b0, cnt_inc};
                        mem_wdata_q <= we_q ? {24'b0, next_byte} : 32'b0;
                    end
                end
                RESP: begin
                    state_q      <= IDLE;
                    resp_valid_q <= 1'b0;
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= 32'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign MemRead    = mem_read_q;
    assign MemWrite   = mem_write_q;
    assign mem_addr   = mem_addr_q;
    assign mem_func3  = mem_func3_q;
    assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_lsu_byte_master.sv
// tb/tb_lsu_byte_master.sv - scoreboard bench for lsu_byte_master with byte memory and reference model
module tb_lsu_byte_master;

    localparam int LIM = 4096;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_func3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] mem_addr;
    logic [2:0]  mem_func3;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    lsu_byte_master #(.ADDR_LIMIT(LIM)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_func3(req_func3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .MemRead(MemRead), .MemWrite(MemWrite), .mem_addr(mem_addr),
        .mem_func3(mem_func3), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    logic [7:0] mem [LIM];
    logic [7:0] ref_mem [LIM];

    assign mem_rdata = (MemRead && mem_addr < LIM) ? {24'b0, mem[mem_addr[11:0]]} : 32'b0;
    always @(posedge clk) if (MemWrite && mem_addr < LIM) mem[mem_addr[11:0]] <= mem_wdata[7:0];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          beats;
        logic [31:0] base;
        logic        we;
        logic [31:0] wd;
        int          at;
    } exp_t;

    exp_t sb[$];
    int compared = 0;
    int mismatched = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: bytes in ascending address order, little-endian, then sign/zero extend.
    function automatic exp_t model(input logic we, input logic [2:0] f3,
                                   input logic [31:0] a, input logic [31:0] wd);
        exp_t e;
        longint v;
        longint unsigned last_end;
        int n;
        bit legal;
        e.we = we; e.base = a; e.wd = wd; e.rdata = 32'b0; e.err = 1'b0; e.at = 0; e.beats = 0;
        n = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        last_end = longint'({32'b0, a}) + n;
        if (!legal || last_end > LIM) begin
            e.err = 1'b1;
            return e;
        end
        e.beats = n;
        if (we) begin
            for (int i = 0; i < n; i++) ref_mem[int'(a) + i] = wd[8*i +: 8];
        end else begin
            v = 0;
            for (int i = 0; i < n; i++) v += longint'(ref_mem[int'(a) + i]) << (8 * i);
            if (f3[2] == 1'b0 && n < 4 && v >= (longint'(1) << (8 * n - 1)))
                v -= (longint'(1) << (8 * n));
            e.rdata = v[31:0];
        end
        return e;
    endfunction

    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input bit track);
        int guard;
        exp_t e;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_func3 = f3; req_addr = a; req_wdata = wd;
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) begin
            chk("accept_timeout", 64'd0, 64'd1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_wdata = $urandom;
        if (track) begin
            e = model(we, f3, a, wd);
            e.at = cyc;
            sb.push_back(e);
        end
    endtask

    // Monitor: checks every beat against the pending transaction and every response against the queue head.
    initial begin
        int beats;
        exp_t e;
        beats = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                beats = 0;
            end else begin
                chk("strobe_excl", 64'(MemRead & MemWrite), 64'd0);
                if (MemRead || MemWrite) begin
                    if (sb.size() > 0) begin
                        chk("beat_addr", 64'(mem_addr), 64'(sb[0].base + beats));
                        chk("beat_kind", 64'({MemRead, MemWrite, mem_func3}),
                            sb[0].we ? 64'b01000 : 64'b10100);
                        if (beats < 4)
                            chk("beat_wdata", 64'(mem_wdata),
                                sb[0].we ? 64'(sb[0].wd[8*beats +: 8]) : 64'd0);
                        else
                            chk("beat_overrun", 64'(beats), 64'd3);
                    end
                    beats++;
                end else begin
                    chk("idle_bus", 64'({mem_addr, mem_wdata, mem_func3}), 64'd0);
                end
                if (resp_valid) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_resp", 64'd1, 64'd0);
                    end else begin
                        e = sb.pop_front();
                        chk("resp_rdata", 64'(resp_rdata), 64'(e.rdata));
                        chk("resp_err", 64'(resp_err), 64'(e.err));
                        chk("beat_count", 64'(beats), 64'(e.beats));
                        chk("resp_cycle", 64'(cyc), 64'(e.at + e.beats));
                    end
                    beats = 0;
                end else begin
                    chk("resp_quiet", 64'({resp_rdata, resp_err}), 64'd0);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", compared);
        $fatal(1, "watchdog");
    end

    task automatic drain();
        int guard;
        guard = 0;
        while (sb.size() != 0 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("drain", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        int bad;
        int r;
        logic [31:0] a;
        for (int i = 0; i < LIM; i++) begin
            mem[i] = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        mem[32'h101] = 8'h34; ref_mem[32'h101] = 8'h34;
        mem[32'h102] = 8'h92; ref_mem[32'h102] = 8'h92;
        mem[32'h020] = 8'h80; ref_mem[32'h020] = 8'h80;

        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_func3 = 3'b0;
        req_addr = 32'b0; req_wdata = 32'b0;
        repeat (2) @(negedge clk);
        chk("rst_resp", 64'({resp_valid, resp_err, resp_rdata}), 64'd0);
        chk("rst_mem_bus", 64'({MemRead, MemWrite, mem_addr, mem_func3}), 64'd0);
        chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", 64'(req_ready), 64'd1);

        issue(1'b0, 3'b001, 32'h101, 32'h0, 1'b1);
        issue(1'b0, 3'b101, 32'h101, 32'h0, 1'b1);
        issue(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 1'b1);
        issue(1'b0, 3'b010, 32'h100, 32'h0, 1'b1);
        issue(1'b0, 3'b000, 32'h020, 32'h0, 1'b1);
        issue(1'b0, 3'b100, 32'h020, 32'h0, 1'b1);
        issue(1'b0, 3'b011, 32'h040, 32'h0, 1'b1);
        issue(1'b1, 3'b100, 32'h040, 32'h5A, 1'b1);
        issue(1'b0, 3'b010, 32'hFFE, 32'h0, 1'b1);
        issue(1'b0, 3'b010, 32'hFFC, 32'h0, 1'b1);
        issue(1'b1, 3'b001, 32'hFFF, 32'h1234, 1'b1);
        issue(1'b0, 3'b000, 32'hFFF, 32'h0, 1'b1);
        issue(1'b0, 3'b010, 32'hFFFFFFFE, 32'h0, 1'b1);

        for (int t = 0; t < 300; t++) begin
            r = $urandom_range(0, 9);
            if (r < 7)      a = 32'($urandom_range(0, LIM - 1));
            else if (r < 9) a = 32'($urandom_range(LIM - 6, LIM + 2));
            else            a = $urandom;
            issue(1'($urandom), 3'($urandom), a, $urandom, 1'b1);
        end
        drain();

        issue(1'b1, 3'b010, 32'h200, 32'h11223344, 1'b0);
        repeat (3) @(negedge clk);
        chk("abort_beat2", 64'({MemWrite, mem_addr}), 64'({1'b1, 32'h202}));
        rst_n = 1'b0;
        #1;
        chk("abort_strobes", 64'({MemRead, MemWrite, mem_addr}), 64'd0);
        chk("abort_resp", 64'(resp_valid), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ref_mem[32'h200] = 8'h44;
        ref_mem[32'h201] = 8'h33;
        @(negedge clk);
        chk("abort_ready", 64'(req_ready), 64'd1);
        issue(1'b0, 3'b010, 32'h200, 32'h0, 1'b1);
        issue(1'b0, 3'b001, 32'h202, 32'h0, 1'b1);
        drain();
        repeat (3) @(negedge clk);

        bad = 0;
        for (int i = 0; i < LIM; i++) if (mem[i] !== ref_mem[i]) bad++;
        chk("mem_image", 64'(bad), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
